// File: rtl/pending_priority_encoder.sv
// pending_priority_encoder
//
// This block latches request bits into a pending register. It presents the
// index of one selected pending request that is not masked, together with a
// valid flag. The consumer retires the presented index with ACK. There are
// two selection modes:
// fixed priority, where the highest index wins, and round-robin, where the
// search starts just after the last retired index.
//
// Parameters
//   N        request width (2..32; widths that are not a power of 2 are fine)
//   RR_MODE  0 = fixed priority (highest index), 1 = round-robin
//   W        output index width, derived from N
//
// Ports
//   CLK    in   1  clock; all state changes on the rising edge
//   RST    in   1  synchronous, active-high reset
//   A      in   N  request bits, level-sampled; a 1 sets the pending bit
//   MASK   in   N  1 = bit excluded from selection; pending state is kept
//   ACK    in   1  retire the presented index; ignored while VALID=0
//   O      out  W  selected index; 0 when VALID=0
//   VALID  out  1  O names a pending request that is not masked
//   PEND   out  N  pending register
//   DROP   out  1  one-cycle pulse: a request hit a bit that was already pending
//
// Every output comes straight from a register, so no input reaches an
// output combinationally.

module pending_priority_encoder #(
   parameter  int N       = 8,
   parameter  int RR_MODE = 0,
   localparam int W       = (N > 1) ? $clog2(N) : 1
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic [N-1:0] A,
   input  logic [N-1:0] MASK,
   input  logic         ACK,
   output logic [W-1:0] O,
   output logic         VALID,
   output logic [N-1:0] PEND,
   output logic         DROP
);

   localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

   logic [N-1:0] p_q, p_d;
   logic [W-1:0] o_q, o_d;
   logic         valid_q, valid_d;
   logic         drop_q, drop_d;
   logic [W-1:0] last_q, last_d;

   logic         honour;
   logic [N-1:0] clr;
   logic [N-1:0] cand;
   logic [W-1:0] sel_fixed;
   logic [W-1:0] sel_rr;
   logic         found_rr;
   int           rr_start;
   int           rr_idx;

   always_comb begin
      honour = ACK & valid_q;
      clr    = honour ? (ONE_N << o_q) : '0;

      // When a bit is set and cleared in the same cycle, the set wins.
      // That bit also does not count as a drop, because the clear has
      // already retired it.
      p_d    = (p_q & ~clr) | A;
      drop_d = |(A & p_q & ~clr);

      // LAST follows the retired index. The search then begins at the
      // index just after it.
      last_d = honour ? o_q : last_q;

      cand    = p_d & ~MASK;
      valid_d = |cand;

      // Fixed priority: scan upwards and keep overwriting, so the highest
      // set index is the one left at the end.
      sel_fixed = '0;
      for (int i = 0; i < N; i++) begin
         if (cand[i]) sel_fixed = W'(i);
      end

      // Round-robin: the first set index, searching upwards from
      // (LAST+1) mod N and wrapping past N-1 to 0.
      rr_start = (int'(last_d) + 1) % N;
      sel_rr   = '0;
      found_rr = 1'b0;
      rr_idx   = 0;
      for (int k = 0; k < N; k++) begin
         rr_idx = rr_start + k;
         if (rr_idx >= N) rr_idx = rr_idx - N;
         if (!found_rr && cand[rr_idx]) begin
            sel_rr   = W'(rr_idx);
            found_rr = 1'b1;
         end
      end

      if (!valid_d)          o_d = '0;
      else if (RR_MODE != 0) o_d = sel_rr;
      else                   o_d = sel_fixed;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         p_q     <= '0;
         o_q     <= '0;
         valid_q <= 1'b0;
         drop_q  <= 1'b0;
         last_q  <= W'(N - 1);
      end else begin
         p_q     <= p_d;
         o_q     <= o_d;
         valid_q <= valid_d;
         drop_q  <= drop_d;
         last_q  <= last_d;
      end
   end

   assign O     = o_q;
   assign VALID = valid_q;
   assign PEND  = p_q;
   assign DROP  = drop_q;

endmodule

// File: tb/tb_pending_priority_encoder.sv
// Bench for pending_priority_encoder. It uses three instances:
//   dut 0: N=8, fixed priority
//   dut 1: N=8, round-robin
//   dut 2: N=5, fixed priority (width that is not a power of 2)
// Each directed step drives the inputs and queues the outputs expected
// after the next rising edge. The queued values are checked 1 time unit
// after that edge.

module tb_pending_priority_encoder;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] a0, mask0, a1, mask1;
   logic [4:0] a2, mask2;
   logic       ack0, ack1, ack2;

   logic [2:0] o0, o1, o2;
   logic       v0, v1, v2, d0, d1, d2;
   logic [7:0] p0, p1;
   logic [4:0] p2;

   int compared   = 0;
   int mismatched = 0;
   int step_no    = 0;

   typedef struct {
      int         dut;
      int         step;
      logic [7:0] pend;
      logic [2:0] o;
      logic       valid;
      logic       drop;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   pending_priority_encoder #(.N(8), .RR_MODE(0)) u_fix (
      .CLK(clk), .RST(rst), .A(a0), .MASK(mask0), .ACK(ack0),
      .O(o0), .VALID(v0), .PEND(p0), .DROP(d0));

   pending_priority_encoder #(.N(8), .RR_MODE(1)) u_rr (
      .CLK(clk), .RST(rst), .A(a1), .MASK(mask1), .ACK(ack1),
      .O(o1), .VALID(v1), .PEND(p1), .DROP(d1));

   pending_priority_encoder #(.N(5), .RR_MODE(0)) u_n5 (
      .CLK(clk), .RST(rst), .A(a2), .MASK(mask2), .ACK(ack2),
      .O(o2), .VALID(v2), .PEND(p2), .DROP(d2));

   task automatic chk(input string tag, input int dut, input int step,
                      input logic [7:0] obs, input logic [7:0] exp_v);
      compared++;
      assert (obs === exp_v) else begin
         mismatched++;
         $error("FAIL %s dut%0d step %0d: observed %0h expected %0h",
                tag, dut, step, obs, exp_v);
      end
   endtask

   task automatic expect_out(input int dut, input logic [7:0] pend,
                             input logic [2:0] o, input logic valid,
                             input logic drop);
      exp_t e;
      e.dut   = dut;
      e.step  = step_no;
      e.pend  = pend;
      e.o     = o;
      e.valid = valid;
      e.drop  = drop;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      exp_t       e;
      logic [7:0] op, oo, ov, od;
      @(posedge clk);
      #1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         case (e.dut)
            0:       begin op = p0;          oo = {5'd0, o0}; ov = {7'd0, v0}; od = {7'd0, d0}; end
            1:       begin op = p1;          oo = {5'd0, o1}; ov = {7'd0, v1}; od = {7'd0, d1}; end
            default: begin op = {3'd0, p2};  oo = {5'd0, o2}; ov = {7'd0, v2}; od = {7'd0, d2}; end
         endcase
         chk("pend",  e.dut, e.step, op, e.pend);
         chk("o",     e.dut, e.step, oo, {5'd0, e.o});
         chk("valid", e.dut, e.step, ov, {7'd0, e.valid});
         chk("drop",  e.dut, e.step, od, {7'd0, e.drop});
      end
      step_no++;
   endtask

   task automatic expect_idle(input int dut);
      expect_out(dut, 8'h00, 3'd0, 1'b0, 1'b0);
   endtask

   initial begin
      // Reset. Requests and acknowledges driven during it must be ignored.
      rst = 1'b1;
      a0 = 8'hFF; mask0 = 8'h00; ack0 = 1'b1;
      a1 = 8'hFF; mask1 = 8'h00; ack1 = 1'b1;
      a2 = 5'h1F; mask2 = 5'h00; ack2 = 1'b1;
      expect_idle(0); expect_idle(1); expect_idle(2);
      tick();
      rst = 1'b0;
      a0 = 8'h00; ack0 = 1'b0;
      a1 = 8'h00; ack1 = 1'b0;
      a2 = 5'h00; ack2 = 1'b0;
      expect_idle(0); expect_idle(1); expect_idle(2);
      tick();

      // Basic request and retire.
      a0 = 8'h01;               expect_out(0, 8'h01, 3'd0, 1'b1, 1'b0); tick();
      a0 = 8'h00; ack0 = 1'b1;  expect_idle(0);                        tick();

      // Fixed priority, with ACK held so one request retires per cycle.
      ack0 = 1'b0; a0 = 8'b1001_0010;
      expect_out(0, 8'h92, 3'd7, 1'b1, 1'b0); tick();
      a0 = 8'h00; ack0 = 1'b1;
      expect_out(0, 8'h12, 3'd4, 1'b1, 1'b0); tick();
      expect_out(0, 8'h02, 3'd1, 1'b1, 1'b0); tick();
      expect_idle(0);                         tick();
      // An ACK while nothing is valid has no effect.
      expect_idle(0);                         tick();
      ack0 = 1'b0;

      // A masked request stays pending. An ACK while VALID=0 does not clear it.
      a0 = 8'h80; mask0 = 8'h80; expect_out(0, 8'h80, 3'd0, 1'b0, 1'b0); tick();
      a0 = 8'h00; ack0 = 1'b1;   expect_out(0, 8'h80, 3'd0, 1'b0, 1'b0); tick();
      ack0 = 1'b0; mask0 = 8'h00; expect_out(0, 8'h80, 3'd7, 1'b1, 1'b0); tick();
      ack0 = 1'b1;               expect_idle(0);                        tick();
      ack0 = 1'b0;

      // DROP: a second request on a bit that is already pending.
      a0 = 8'h04; expect_out(0, 8'h04, 3'd2, 1'b1, 1'b0); tick();
      a0 = 8'h04; expect_out(0, 8'h04, 3'd2, 1'b1, 1'b1); tick();
      a0 = 8'h00; expect_out(0, 8'h04, 3'd2, 1'b1, 1'b0); tick();
      // Set and clear on the same bit: the set wins and DROP stays low.
      a0 = 8'h04; ack0 = 1'b1; expect_out(0, 8'h04, 3'd2, 1'b1, 1'b0); tick();
      a0 = 8'h00; ack0 = 1'b0;

      // Masking the presented index withdraws it without clearing it.
      a0 = 8'h08;               expect_out(0, 8'h0C, 3'd3, 1'b1, 1'b0); tick();
      a0 = 8'h00; mask0 = 8'h08; expect_out(0, 8'h0C, 3'd2, 1'b1, 1'b0); tick();
      mask0 = 8'h0C;            expect_out(0, 8'h0C, 3'd0, 1'b0, 1'b0); tick();
      mask0 = 8'h00;            expect_out(0, 8'h0C, 3'd3, 1'b1, 1'b0); tick();
      ack0 = 1'b1;              expect_out(0, 8'h04, 3'd2, 1'b1, 1'b0); tick();
                                expect_idle(0);                        tick();
      ack0 = 1'b0;

      // Round-robin: all requests, ACK every cycle, so O walks 0..7.
      a1 = 8'hFF; expect_out(1, 8'hFF, 3'd0, 1'b1, 1'b0); tick();
      a1 = 8'h00; ack1 = 1'b1;
      for (int i = 1; i < 8; i++) begin
         expect_out(1, 8'hFF << i, 3'(i), 1'b1, 1'b0);
         tick();
      end
      expect_idle(1); tick();
      ack1 = 1'b0;
      // LAST=7: the search starts at 0.
      a1 = 8'h09;              expect_out(1, 8'h09, 3'd0, 1'b1, 1'b0); tick();
      a1 = 8'h00; ack1 = 1'b1; expect_out(1, 8'h08, 3'd3, 1'b1, 1'b0); tick();
                               expect_idle(1);                        tick();
      // Bring LAST to 2. The search starts at 4 and wraps round to 2.
      ack1 = 1'b0; a1 = 8'h04; expect_out(1, 8'h04, 3'd2, 1'b1, 1'b0); tick();
      a1 = 8'h00; ack1 = 1'b1; expect_idle(1);                        tick();
      // LAST=2: the search starts at 3, and after 3 retires it wraps to 0.
      ack1 = 1'b0; a1 = 8'h09; expect_out(1, 8'h09, 3'd3, 1'b1, 1'b0); tick();
      a1 = 8'h00; ack1 = 1'b1; expect_out(1, 8'h01, 3'd0, 1'b1, 1'b0); tick();
                               expect_idle(1);                        tick();
      ack1 = 1'b0;

      // N=5: the top index is 4, and fixed priority still picks the highest.
      a2 = 5'b10000;           expect_out(2, 8'h10, 3'd4, 1'b1, 1'b0); tick();
      a2 = 5'b00011;           expect_out(2, 8'h13, 3'd4, 1'b1, 1'b0); tick();
      a2 = 5'b00000; ack2 = 1'b1; expect_out(2, 8'h03, 3'd1, 1'b1, 1'b0); tick();
                               expect_out(2, 8'h01, 3'd0, 1'b1, 1'b0); tick();
                               expect_idle(2);                        tick();
      ack2 = 1'b0;

      // Reset mid-operation, with requests and ACK both active.
      a0 = 8'hFF;              expect_out(0, 8'hFF, 3'd7, 1'b1, 1'b0); tick();
      rst = 1'b1; ack0 = 1'b1; expect_idle(0);                        tick();
      rst = 1'b0; a0 = 8'h00; ack0 = 1'b0;
      expect_idle(0); expect_idle(1); expect_idle(2);                 tick();

      compared++;
      assert (exp_q.size() == 0) else begin
         mismatched++;
         $error("FAIL queue_drain: observed %0d entries expected 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/pending_priority_encoder.md
# pending_priority_encoder

Parametrised, registered successor to the 8-to-3 encoder. Latches incoming request bits into a pending register and presents the index of the selected pending, unmasked request with a valid flag. The consumer retires the presented index with an acknowledge. Fixed-priority and round-robin selection are both supported, for use as an interrupt/request front end in the chapter designs.

## Interface
- N, 8: request width; legal range 2..32, non-power-of-2 allowed.
- W, $clog2(N): output index width; derived, not overridden.
- RR_MODE, 0: selection mode. 0 = fixed priority, highest index wins. 1 = round-robin.
- CLK  in  1  single clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- A  in  N  request bits, level-sampled every cycle; any 1 sets the matching pending bit.
- MASK  in  N  1 = bit excluded from selection; its pending state is retained.
- ACK  in  1  retire the currently presented index; honoured only while VALID=1.
- O  out  W  selected index; forced to 0 when VALID=0.
- VALID  out  1  O holds a pending, unmasked request.
- PEND  out  N  pending register, direct view.
- DROP  out  1  one-cycle pulse: a request hit a bit that was already pending.

## Operation
- Pending register P is N bits.
  - clr = onehot(O) when ACK & VALID, else 0.
  - P_next = (P & ~clr) | A.
- Set and clear on the same bit in the same cycle: set wins. The bit stays pending and DROP is not raised for that bit.
- DROP_next = |(A & P & ~clr).
- Candidate set C = P_next & ~MASK.
- VALID_next = |C.
- O_next:
  - RR_MODE=0: highest set index of C.
  - RR_MODE=1: first set index of C searching ascending from (LAST+1) mod N, wrapping past N-1 to 0.
  - 0 when C is empty.
- LAST (RR_MODE=1 only; internal, W bits) loads O on every honoured ACK. It is unchanged otherwise.
- ACK while VALID=0 is ignored: P, LAST and O are not affected.
- Changing MASK re-evaluates selection on the next edge. A presented index that becomes masked is withdrawn without being cleared.
- O never exceeds N-1 for any N.

## Timing
- Reset (RST=1 at an edge):
  - P=0, O=0, VALID=0, DROP=0, LAST=N-1.
  - RR_MODE=1 therefore starts its search at index 0.
  - A and ACK are ignored during the reset cycle, including reset asserted mid-operation.
- Request latency is 1 cycle. A sampled at edge k appears on PEND, O and VALID after edge k.
- Acknowledge latency is 1 cycle. ACK at edge k clears the bit, and the next selection is presented after the same edge k. Back-to-back ACK every cycle retires one request per cycle.
- MASK latency is 1 cycle.
- DROP is registered. It asserts for exactly the cycle after the offending edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
All scenarios use N=8 unless stated.
1. Basic request and retire (RR_MODE=0):
   - After reset, A=8'h01 for 1 cycle -> next cycle O=0, VALID=1, PEND=8'h01.
   - ACK for 1 cycle -> next cycle VALID=0, O=0, PEND=0.
2. Fixed priority (RR_MODE=0):
   - A=8'b10010010 for 1 cycle -> O=7.
   - ACK held -> O=4, then O=1, then VALID=0 on consecutive cycles.
3. Mask hold and release:
   - A=8'h80 with MASK=8'h80 -> VALID=0, PEND=8'h80.
   - MASK=0 -> next cycle O=7, VALID=1.
4. DROP behaviour:
   - A=8'h04 on two consecutive cycles, no ACK -> DROP=1 for one cycle after the second edge.
   - Then A=8'h04 with ACK on bit 2 -> PEND bit 2 stays 1, DROP=0.
5. Round-robin (RR_MODE=1):
   - A=8'hFF, ACK every cycle -> O = 0,1,2,...,7, then VALID=0.
   - Then with LAST=7, A=8'h09 -> O=0; ACK -> O=3.
   - Separately with LAST=2, A=8'h09 -> O=3, then O=0.
6. Reset mid-operation and non-power-of-2 width:
   - PEND=8'hFF, then RST=1 together with A=8'hFF and ACK=1 -> next cycle PEND=0, VALID=0, DROP=0.
   - With N=5 (W=3), A=5'b10000 -> O=4.
